// File: rtl/fsm_pkg.sv
// Shared constants for the ALU-instruction control FSMs: opcodes, funct fields,
// state encoding and rd-source selects.
package fsm_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;

    typedef logic [3:0] state_t;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_EXEC_U    = 4'd4;
    localparam logic [3:0] S_MD_START  = 4'd5;
    localparam logic [3:0] S_MD_WAIT   = 4'd6;
    localparam logic [3:0] S_WRITEBACK = 4'd7;
    localparam logic [3:0] S_TRAP      = 4'd8;

    localparam logic [1:0] SEL_RD_ALU = 2'b10;
    localparam logic [1:0] SEL_RD_MD  = 2'b11;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SR);
    endfunction

endpackage

// File: rtl/alu_insn_decode.sv
// Combinational class/legality decoder for integer ALU instructions.
// Class flags are only asserted for legal encodings; is_w reflects the opcode alone.
module alu_insn_decode
    import fsm_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_W = 1'b1
) (
    input  logic [31:0] insn,
    output logic        is_r,
    output logic        is_i,
    output logic        is_u,
    output logic        is_md,
    output logic        is_w,
    output logic        illegal_dec
);

    logic [6:0] w_opc;
    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic       w_w_ok;
    logic       w_shamt_ok;
    logic       w_unused_bits;

    assign w_opc         = insn[6:0];
    assign w_f3          = insn[14:12];
    assign w_f7          = insn[31:25];
    assign w_w_ok        = ENABLE_W && (XLEN == 64);
    assign w_unused_bits = ^{insn[24:15], insn[11:7]};
    assign is_w          = (w_opc == OPC_OP32) || (w_opc == OPC_OP_IMM32);

    // RV64 OP-IMM shifts carry a 6-bit shamt; W forms and RV32 carry 5 bits.
    // The arithmetic-shift marker is only meaningful for right shifts.
    always_comb begin
        w_shamt_ok = 1'b0;
        if ((XLEN == 64) && (w_opc == OPC_OP_IMM)) begin
            w_shamt_ok = (insn[31:26] == 6'b000000) ||
                         ((insn[31:26] == 6'b010000) && (w_f3 == F3_SR));
        end else begin
            w_shamt_ok = (w_f7 == F7_BASE) ||
                         ((w_f7 == F7_ALT) && (w_f3 == F3_SR));
        end
    end

    always_comb begin
        is_r        = 1'b0;
        is_i        = 1'b0;
        is_u        = 1'b0;
        is_md       = 1'b0;
        illegal_dec = 1'b0;
        case (w_opc)
            OPC_OP, OPC_OP32: begin
                if ((w_opc == OPC_OP32) && !w_w_ok) begin
                    illegal_dec = 1'b1;
                end else if (w_f7 == F7_BASE) begin
                    is_r = 1'b1;
                end else if ((w_f7 == F7_ALT) &&
                             ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SR))) begin
                    is_r = 1'b1;
                end else if ((w_f7 == F7_MULDIV) && ENABLE_M) begin
                    is_md = 1'b1;
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                if ((w_opc == OPC_OP_IMM32) && !w_w_ok) begin
                    illegal_dec = 1'b1;
                end else if ((w_opc == OPC_OP_IMM32) &&
                             (w_f3 != F3_ADD_SUB) && !is_shift_f3(w_f3)) begin
                    illegal_dec = 1'b1;
                end else if (is_shift_f3(w_f3) && !w_shamt_ok) begin
                    illegal_dec = 1'b1;
                end else begin
                    is_i = 1'b1;
                end
            end
            OPC_AUIPC: begin
                is_u = 1'b1;
            end
            default: begin
                illegal_dec = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fsm_alu_ext.sv
// Control FSM sequencing integer ALU instructions, with an optional hand-off to an
// external mul/div unit guarded by a watchdog, and an illegal-instruction trap path.
module fsm_alu_ext
    import fsm_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter bit ENABLE_M   = 1'b1,
    parameter bit ENABLE_W   = 1'b1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] insn,
    input  logic        md_done,
    output logic [1:0]  sel_rd,
    output logic        load_rs1,
    output logic        load_rs2,
    output logic        load_imm,
    output logic        load_alu,
    output logic        sel_alu_a,
    output logic        sel_alu_b,
    output logic        sub_sra,
    output logic        word_op,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        load_pc,
    output logic        load_regfile,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  dbg_state
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MD_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_insn_q;
    logic [CNT_W-1:0] r_wdog;

    logic w_is_r;
    logic w_is_i;
    logic w_is_u;
    logic w_is_md;
    logic w_is_w;
    logic w_illegal_dec;

    alu_insn_decode #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M),
        .ENABLE_W (ENABLE_W)
    ) u_dec (
        .insn        (r_insn_q),
        .is_r        (w_is_r),
        .is_i        (w_is_i),
        .is_u        (w_is_u),
        .is_md       (w_is_md),
        .is_w        (w_is_w),
        .illegal_dec (w_illegal_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_insn_q <= '0;
            r_wdog   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && start) begin
                r_insn_q <= insn;
            end
            if (r_state == S_MD_START) begin
                r_wdog <= '0;
            end else if (r_state == S_MD_WAIT) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end
        end
    end

    // md_done is checked before the watchdog so a result arriving on the
    // last permitted cycle still commits.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_illegal_dec) begin
                    w_next_state = S_TRAP;
                end else if (w_is_md) begin
                    w_next_state = S_MD_START;
                end else if (w_is_r) begin
                    w_next_state = S_EXEC_R;
                end else if (w_is_i) begin
                    w_next_state = S_EXEC_I;
                end else if (w_is_u) begin
                    w_next_state = S_EXEC_U;
                end else begin
                    w_next_state = S_TRAP;
                end
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: begin
                w_next_state = S_WRITEBACK;
            end
            S_MD_START: begin
                w_next_state = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                if (md_done) begin
                    w_next_state = S_WRITEBACK;
                end else if (r_wdog == WDOG_LAST) begin
                    w_next_state = S_TRAP;
                end
            end
            S_WRITEBACK, S_TRAP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_rd       = 2'b00;
        load_rs1     = 1'b0;
        load_rs2     = 1'b0;
        load_imm     = 1'b0;
        load_alu     = 1'b0;
        sel_alu_a    = 1'b0;
        sel_alu_b    = 1'b0;
        sub_sra      = 1'b0;
        word_op      = 1'b0;
        md_start     = 1'b0;
        md_op        = 3'b000;
        load_pc      = 1'b0;
        load_regfile = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        case (r_state)
            S_DECODE: begin
                load_rs1 = 1'b1;
                load_rs2 = 1'b1;
                load_imm = 1'b1;
            end
            S_EXEC_R: begin
                load_alu = 1'b1;
                sub_sra  = r_insn_q[30];
                word_op  = w_is_w;
            end
            S_EXEC_I: begin
                // insn_q[30] is immediate data except on right shifts.
                load_alu  = 1'b1;
                sel_alu_b = 1'b1;
                sub_sra   = (r_insn_q[14:12] == F3_SR) && r_insn_q[30];
                word_op   = w_is_w;
            end
            S_EXEC_U: begin
                load_alu  = 1'b1;
                sel_alu_a = 1'b1;
                sel_alu_b = 1'b1;
            end
            S_MD_START: begin
                md_start = 1'b1;
                md_op    = r_insn_q[14:12];
                word_op  = w_is_w;
            end
            S_MD_WAIT: begin
                md_op = r_insn_q[14:12];
            end
            S_WRITEBACK: begin
                load_pc      = 1'b1;
                load_regfile = 1'b1;
                done         = 1'b1;
                sel_rd       = w_is_md ? SEL_RD_MD : SEL_RD_ALU;
            end
            S_TRAP: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = r_state;

endmodule

// File: doc/fsm_alu_ext.md
Name: fsm_alu_ext

Overview:
- Parametrised successor of the ALU-instruction control FSM. Sequences all integer ALU instructions: OP, OP-IMM, OP-32, OP-IMM-32, AUIPC.
- Adds three things: optional M-extension ops handed off to an external multi-cycle mul/div unit over a start/done handshake; a watchdog on that handshake; an illegal-instruction trap path.
- Sits inside the Control Unit beside the other FSMs. It is enabled by the dispatcher's start pulse and returns done.

Parameters:
- XLEN, 64, datapath width (32 or 64); governs shamt width and W-op legality.
- ENABLE_M, 1, accept funct7=0000001 ops on OP/OP-32; when 0 they trap.
- ENABLE_W, 1, accept OP-32/OP-IMM-32; forced illegal when XLEN=32.
- MD_TIMEOUT, 64, maximum cycles waiting for md_done before trapping.
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  dispatch pulse, sampled only in IDLE
- insn  in  32  current instruction, captured into insn_q when start is accepted
- md_done  in  1  mul/div unit result valid (level, held until next md_start)
- sel_rd  out  2  rd source: 2'b10 ALU result, 2'b11 mul/div result
- load_rs1, load_rs2, load_imm  out  1  operand register loads
- load_alu  out  1  ALU output register load
- sel_alu_a  out  1  ALU A source: 1 = PC (AUIPC), 0 = rs1
- sel_alu_b  out  1  ALU B source: 1 = immediate, 0 = rs2
- sub_sra  out  1  subtract / arithmetic-shift select
- word_op  out  1  32-bit op: datapath truncates to 32 bits and sign-extends to XLEN
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_op  out  3  insn_q[14:12] forwarded to the mul/div unit
- load_pc, load_regfile  out  1  commit strobes
- done  out  1  instruction finished (one cycle)
- illegal  out  1  trap indication, asserted together with done

Behaviour:
- Reset (async, active-high): state=IDLE, insn_q=0, wdog=0. All outputs are 0 while reset is high and in IDLE. Reset mid-operation abandons the instruction with no commit.
- Outputs are Moore-style, decoded from state and insn_q only. insn is never used after capture.
- States: IDLE, DECODE, EXEC_R, EXEC_I, EXEC_U, MD_START, MD_WAIT, WRITEBACK, TRAP.
- IDLE: on start=1, capture insn and go to DECODE; otherwise stay.
- DECODE: assert load_rs1, load_rs2, load_imm. Next state:
  - EXEC_R for OP/OP-32 with funct7 in {0000000, 0100000}.
  - MD_START for OP/OP-32 with funct7=0000001 and ENABLE_M=1.
  - EXEC_I for OP-IMM/OP-IMM-32.
  - EXEC_U for AUIPC.
  - TRAP otherwise.
- Illegal (leads to TRAP):
  - unknown opcode;
  - W opcode with ENABLE_W=0;
  - funct7=0100000 with funct3 other than 000 or 101;
  - OP-IMM shift with nonzero bits above shamt (XLEN=64: insn[31:26] not in {000000, 010000}; XLEN=32 and W forms: insn[31:25] not in {0000000, 0100000});
  - OP-IMM-32 funct3 other than 000, 001 or 101.
- EXEC_R: load_alu=1, sel_alu_b=0, sub_sra=insn_q[30], word_op if OP-32. Next WRITEBACK.
- EXEC_I: load_alu=1, sel_alu_b=1, sub_sra=insn_q[30] only when funct3=101 (else 0), word_op if OP-IMM-32. Next WRITEBACK.
- EXEC_U: load_alu=1, sel_alu_a=1, sel_alu_b=1, sub_sra=0. Next WRITEBACK.
- MD_START: md_start=1 for exactly one cycle, wdog cleared, word_op if OP-32. Next MD_WAIT.
- MD_WAIT: wdog increments each cycle.
  - md_done=1 goes to WRITEBACK. md_done wins if it coincides with the timeout.
  - wdog==MD_TIMEOUT-1 without md_done goes to TRAP.
- WRITEBACK: load_pc=1, load_regfile=1, done=1. sel_rd=2'b11 if the path was mul/div, else 2'b10. Next IDLE.
- TRAP: done=1, illegal=1, load_pc=0, load_regfile=0. Next IDLE.
- Latency from the start-accept edge to done: 3 cycles for ALU paths; 3+N for mul/div, where N is the number of MD_WAIT cycles (N ≥ 1); 2 cycles for decode traps.
- start asserted outside IDLE is ignored.
- rd=x0 is not special-cased; the regfile handles it.

Decomposition:
- Shared package fsm_pkg:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_OP32, OPC_OP_IMM32, OPC_AUIPC);
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV);
  - state encoding localparams;
  - SEL_RD_ALU=2'b10, SEL_RD_MD=2'b11.
- One natural sub-module, alu_insn_decode: combinational legality/class decoder on insn_q. It outputs is_r, is_i, is_u, is_md, is_w and illegal_dec, and it is reused by later FSMs.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with start=1 → DECODE, EXEC_R, WRITEBACK; done at cycle 3; sel_rd=10, sub_sra=0, word_op=0.
- SRAIW x5,x6,3 (0x4033529B) → EXEC_I with sel_alu_b=1, sub_sra=1, word_op=1; done at cycle 3.
- MUL x3,x1,x2 (0x022081B3), md_done raised 5 cycles after md_start → md_start is a single-cycle pulse with md_op=000; WRITEBACK with sel_rd=11; done at cycle 3+5.
- MULW with md_done never raised, MD_TIMEOUT=64 → TRAP after 64 MD_WAIT cycles; done=1, illegal=1, load_regfile=0.
- Opcode 0x0000007F, then MUL with ENABLE_M=0, then SRAI with insn[31:26]=100000 → each traps at cycle 2 with illegal=1 and no load_pc.
- Reset asserted asynchronously in MD_WAIT → outputs 0 immediately and state=IDLE. A fresh AUIPC afterwards completes with sel_alu_a=1 and done at cycle 3.
